// File: rtl/agr_sched_pkg.sv
// Shared definitions for the AGRUPATE job scheduler and its helpers.
package agr_sched_pkg;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CFG  = 3'd1;
    localparam state_t ST_ARM  = 3'd2;
    localparam state_t ST_RUN  = 3'd3;
    localparam state_t ST_FIN  = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

    localparam int unsigned DEF_LOG_MAX_ITERS          = 16;
    localparam int unsigned DEF_LOG_MAX_READS_PER_ITER = 16;
    localparam int unsigned DEF_LOG_TIMEOUT            = 20;

endpackage

// File: rtl/agr_sched_watchdog.sv
// Saturating stall counter; expired flags the increment that lands on all-ones.
module agr_sched_watchdog
    import agr_sched_pkg::*;
#(
    parameter int unsigned LOG_TIMEOUT = DEF_LOG_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam logic [LOG_TIMEOUT-1:0] CNT_MAX = '1;

    logic [LOG_TIMEOUT-1:0] cnt;

    // Counter: clear wins over increment, holds once saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + LOG_TIMEOUT'(1);
        end
    end

    // Expiry is seen on the same edge the counter saturates, so the owner reacts without an extra cycle.
    assign expired = ~clr & ((cnt == CNT_MAX) | (inc & (cnt == (CNT_MAX - LOG_TIMEOUT'(1)))));

endmodule

// File: rtl/agr_sched.sv
// Job-level controller for one AGRUPATE instance: configure, gate output, count groups, report end.
module agr_sched
    import agr_sched_pkg::*;
#(
    parameter int unsigned LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
    parameter int unsigned LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER,
    parameter int unsigned CNT_WIDTH              = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER,
    parameter int unsigned LOG_TIMEOUT            = DEF_LOG_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              job_valid,
    output logic                              job_ready,
    input  logic [LOG_MAX_ITERS-1:0]          job_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads,
    input  logic                              abort,
    output logic                              agr_configure,
    output logic [LOG_MAX_ITERS-1:0]          agr_num_iters,
    output logic [LOG_MAX_READS_PER_ITER-1:0] agr_num_reads_per_iter,
    input  logic                              agr_valid_out,
    output logic                              agr_avail_in,
    input  logic                              down_avail,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [CNT_WIDTH-1:0]              groups_done
);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] expected;
    logic                 accept;
    logic                 zero_job;
    logic                 grp_fire;
    logic                 last_grp;
    logic                 wd_inc;
    logic                 wd_clr;
    logic                 wd_expired;

    assign accept   = (state == ST_IDLE) & job_valid;
    assign zero_job = (job_iters == '0) | (job_reads == '0);
    // A group is recorded on the ungated handshake so an abort racing the last group still logs it.
    assign grp_fire = (state == ST_RUN) & agr_valid_out & down_avail;
    assign last_grp = grp_fire & ((groups_done + CNT_WIDTH'(1)) == expected);
    assign wd_inc   = (state == ST_RUN) & ~grp_fire;
    assign wd_clr   = accept | grp_fire;

    agr_sched_watchdog #(
        .LOG_TIMEOUT(LOG_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .inc    (wd_inc),
        .clr    (wd_clr),
        .expired(wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort beats the last group, the last group beats the watchdog.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (job_valid) state_nxt = zero_job ? ST_ERR : ST_CFG;
            ST_CFG:  state_nxt = abort ? ST_IDLE : ST_ARM;
            ST_ARM:  state_nxt = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort)           state_nxt = ST_IDLE;
                else if (last_grp)   state_nxt = ST_FIN;
                else if (wd_expired) state_nxt = ST_ERR;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the state register; avail is gated live by down_avail and abort.
    always_comb begin
        job_ready     = 1'b0;
        agr_configure = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        agr_avail_in  = 1'b0;
        case (state)
            ST_IDLE: job_ready = 1'b1;
            ST_CFG: begin
                agr_configure = 1'b1;
                busy          = 1'b1;
            end
            ST_ARM:  busy = 1'b1;
            ST_RUN: begin
                busy         = 1'b1;
                agr_avail_in = down_avail & ~abort;
            end
            ST_FIN:  done  = 1'b1;
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    // Job fields, expected product and emitted-group counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            agr_num_iters          <= '0;
            agr_num_reads_per_iter <= '0;
            expected               <= '0;
            groups_done            <= '0;
        end else if (accept) begin
            agr_num_iters          <= job_iters;
            agr_num_reads_per_iter <= job_reads;
            expected               <= CNT_WIDTH'(job_iters) * CNT_WIDTH'(job_reads);
            groups_done            <= '0;
        end else if (grp_fire) begin
            groups_done            <= groups_done + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_agr_sched.sv
// Self-checking bench for agr_sched: scoreboard of expected job endings plus cycle checks.
module tb_agr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_iters;
    logic [15:0] job_reads;
    logic        abort;
    logic        agr_configure;
    logic [15:0] agr_num_iters;
    logic [15:0] agr_num_reads_per_iter;
    logic        agr_valid_out;
    logic        agr_avail_in;
    logic        down_avail;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] groups_done;

    typedef struct packed {
        logic        is_err;
        logic [31:0] gd;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cfg_seen = 0;
    int   cfg_exp  = 0;

    always #5 clk = ~clk;

    agr_sched #(.LOG_TIMEOUT(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .job_valid             (job_valid),
        .job_ready             (job_ready),
        .job_iters             (job_iters),
        .job_reads             (job_reads),
        .abort                 (abort),
        .agr_configure         (agr_configure),
        .agr_num_iters         (agr_num_iters),
        .agr_num_reads_per_iter(agr_num_reads_per_iter),
        .agr_valid_out         (agr_valid_out),
        .agr_avail_in          (agr_avail_in),
        .down_avail            (down_avail),
        .busy                  (busy),
        .done                  (done),
        .error                 (error),
        .groups_done           (groups_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done/error pulse must match the next queued job ending.
    always @(negedge clk) begin
        exp_t e;
        if (agr_configure) cfg_seen++;
        if (done || error) begin
            chk("done_and_error", 64'(done & error), 64'(0));
            if (sb.size() == 0) begin
                chk("unexpected_end", 64'({done, error}), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("end_kind", 64'(error), 64'(e.is_err));
                chk("end_groups", 64'(groups_done), 64'(e.gd));
            end
        end
    end

    // Handshake a job in IDLE; returns one cycle after acceptance.
    task automatic start_job(input int it, input int rd);
        job_valid = 1'b1;
        job_iters = 16'(it);
        job_reads = 16'(rd);
        #1;
        chk("accept_ready", 64'(job_ready), 64'(1));
        tick();
        job_valid = 1'b0;
    endtask

    // Full job with optional 1010 backpressure; agr_valid_out held high throughout.
    task automatic run_job(input int it, input int rd, input bit bp);
        int   n   = it * rd;
        int   fires = 0;
        int   cyc = 0;
        logic dn;
        sb.push_back('{is_err: 1'b0, gd: 32'(n)});
        cfg_exp++;
        agr_valid_out = 1'b1;
        down_avail    = 1'b1;
        start_job(it, rd);
        chk("cfg_pulse", 64'(agr_configure), 64'(1));
        chk("cfg_busy", 64'(busy), 64'(1));
        chk("cfg_iters", 64'(agr_num_iters), 64'(it));
        chk("cfg_reads", 64'(agr_num_reads_per_iter), 64'(rd));
        chk("cfg_avail", 64'(agr_avail_in), 64'(0));
        tick();
        chk("arm_cfg_low", 64'(agr_configure), 64'(0));
        chk("arm_avail", 64'(agr_avail_in), 64'(0));
        chk("arm_gd", 64'(groups_done), 64'(0));
        tick();
        while (fires < n && cyc < 4 * n + 8) begin
            dn = bp ? ~cyc[0] : 1'b1;
            down_avail = dn;
            #1;
            chk("avail_mirror", 64'(agr_avail_in), 64'(dn));
            tick();
            if (dn) fires++;
            cyc++;
            chk("gd_count", 64'(groups_done), 64'(fires));
        end
        chk("run_bound", 64'(fires), 64'(n));
        chk("fin_ready", 64'(job_ready), 64'(0));
        chk("fin_busy", 64'(busy), 64'(0));
        chk("fin_done", 64'(done), 64'(1));
        down_avail = 1'b1;
        #1;
        chk("fin_avail", 64'(agr_avail_in), 64'(0));
        agr_valid_out = 1'b0;
        tick();
        chk("idle_ready", 64'(job_ready), 64'(1));
        chk("idle_gd_hold", 64'(groups_done), 64'(n));
        chk("idle_done_low", 64'(done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int idle_cyc;
        rst           = 1'b1;
        job_valid     = 1'b0;
        job_iters     = '0;
        job_reads     = '0;
        abort         = 1'b0;
        agr_valid_out = 1'b0;
        down_avail    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 64'(job_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cfg", 64'(agr_configure), 64'(0));
        chk("rst_gd", 64'(groups_done), 64'(0));
        chk("rst_iters", 64'(agr_num_iters), 64'(0));
        tick();

        // Normal job and the same job under backpressure.
        run_job(2, 3, 1'b0);
        run_job(2, 3, 1'b1);

        // Zero-sized job goes straight to an error pulse with no configure.
        sb.push_back('{is_err: 1'b1, gd: 32'd0});
        start_job(0, 5);
        chk("zero_error", 64'(error), 64'(1));
        chk("zero_cfg", 64'(agr_configure), 64'(0));
        chk("zero_ready", 64'(job_ready), 64'(0));
        tick();
        chk("zero_err_once", 64'(error), 64'(0));
        chk("zero_back_idle", 64'(job_ready), 64'(1));

        // Timeout: two groups, then the stream goes quiet.
        sb.push_back('{is_err: 1'b1, gd: 32'd2});
        cfg_exp++;
        start_job(1, 4);
        tick();
        tick();
        agr_valid_out = 1'b1;
        down_avail    = 1'b1;
        tick();
        tick();
        agr_valid_out = 1'b0;
        chk("to_gd_two", 64'(groups_done), 64'(2));
        idle_cyc = 0;
        while (!error && idle_cyc < 40) begin
            chk("to_busy", 64'(busy), 64'(1));
            tick();
            idle_cyc++;
        end
        chk("to_idle_cycles", 64'(idle_cyc), 64'(15));
        tick();
        chk("to_back_idle", 64'(job_ready), 64'(1));

        // Abort together with the last group of a 1x4 job.
        cfg_exp++;
        start_job(1, 4);
        tick();
        tick();
        agr_valid_out = 1'b1;
        down_avail    = 1'b1;
        repeat (3) tick();
        abort = 1'b1;
        #1;
        chk("abort_avail_drop", 64'(agr_avail_in), 64'(0));
        tick();
        abort         = 1'b0;
        agr_valid_out = 1'b0;
        chk("abort_idle", 64'(job_ready), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_gd", 64'(groups_done), 64'(4));
        chk("abort_no_done", 64'(done), 64'(0));
        tick();

        // Reset in the middle of RUN, then a 1x1 job.
        cfg_exp++;
        start_job(2, 3);
        tick();
        tick();
        agr_valid_out = 1'b1;
        down_avail    = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        agr_valid_out = 1'b0;
        chk("mrst_gd", 64'(groups_done), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_iters", 64'(agr_num_iters), 64'(0));
        chk("mrst_ready", 64'(job_ready), 64'(1));
        chk("mrst_err", 64'(error), 64'(0));
        run_job(1, 1, 1'b0);

        tick();
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("cfg_pulses", 64'(cfg_seen), 64'(cfg_exp));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
